// File: rtl/mem_scan_display.sv
// Read-side scanner for a small switch-written memory: requests one word per
// period (sweeping or holding an address), shadows it and shows it as hex.
module mem_scan_display #(
    parameter int ADDR_WIDTH   = 2,
    parameter int DATA_WIDTH   = 4,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  scan_en,
    input  logic [ADDR_WIDTH-1:0] hold_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] cur_addr,
    output logic [DATA_WIDTH-1:0] cur_data,
    output logic [7:0]            seg,
    output logic                  changed,
    output logic                  sweep_done
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = $clog2(DWELL_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]         DWELL_LOAD = CW'(DWELL_CYCLES);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DWELL = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           dwell_cnt;
    logic                    scan_mode;
    logic [ADDR_WIDTH-1:0]   scan_ptr;
    logic [ADDR_WIDTH-1:0]   target;
    logic [DATA_WIDTH-1:0]   shadow [DEPTH];
    logic [DEPTH-1:0]        valid;
    logic                    differs;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = ST_REQ;
            ST_REQ:   state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_DWELL;
            ST_DWELL: if (dwell_cnt == CNT_ONE) state_next = ST_REQ;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The mode and address are latched on the edge entering REQ, so both
    // rd_en and rd_addr are flop outputs for the whole request cycle.
    assign target  = scan_en ? scan_ptr : hold_addr;
    assign differs = valid[rd_addr] && (shadow[rd_addr] != rd_data);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            scan_mode  <= 1'b0;
            scan_ptr   <= '0;
            dwell_cnt  <= '0;
            cur_addr   <= '0;
            cur_data   <= '0;
            changed    <= 1'b0;
            seg        <= 8'h3F;
            sweep_done <= 1'b0;
            valid      <= '0;
            for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
        end else begin
            rd_en      <= (state_next == ST_REQ);
            sweep_done <= 1'b0;
            if (state_next == ST_REQ) begin
                rd_addr   <= target;
                scan_mode <= scan_en;
            end
            if (state == ST_DWELL) dwell_cnt <= dwell_cnt - CNT_ONE;
            if (state == ST_WAIT) begin
                cur_addr         <= rd_addr;
                cur_data         <= rd_data;
                shadow[rd_addr]  <= rd_data;
                valid[rd_addr]   <= 1'b1;
                changed          <= differs;
                seg              <= {differs, hex7(rd_data)};
                dwell_cnt        <= DWELL_LOAD;
                sweep_done       <= scan_mode && (rd_addr == ADDR_LAST);
                if (scan_mode) scan_ptr <= scan_ptr + ADDR_ONE;
            end
        end
    end
endmodule
